// File: rtl/fft_stage_sequencer_if.sv
// Butterfly request/retire channel between the FFT stage sequencer (master) and the datapath (slave).
interface fft_stage_sequencer_if #(
   parameter int unsigned LOG2N_MAX = 12
);
   logic                 bf_valid;
   logic                 bf_ready;
   logic [LOG2N_MAX-1:0] bf_addr_a;
   logic [LOG2N_MAX-1:0] bf_addr_b;
   logic [LOG2N_MAX-2:0] bf_tw_addr;
   logic                 bf_swap;
   logic                 bf_done;

   modport master (
      output bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, bf_swap,
      input  bf_ready, bf_done
   );

   modport slave (
      input  bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, bf_swap,
      output bf_ready, bf_done
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT; drains in-flight work between stages.
// Optional bit-reverse swap pass before stage 0 is enabled by defining FFT_STAGE_SEQ_BITREV_EN.
module fft_stage_sequencer #(
   parameter int unsigned LOG2N_MAX  = 12,
   parameter int unsigned INFLIGHT_W = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [3:0]                   cfg_log2n,
   fft_stage_sequencer_if.master        bf,
   output logic [3:0]                   stage,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);
   localparam int unsigned AW = LOG2N_MAX;
   localparam int unsigned KW = LOG2N_MAX - 1;
   localparam int unsigned IW = INFLIGHT_W;
   localparam logic [IW-1:0] INFLIGHT_MAX = '1;

`ifdef FFT_STAGE_SEQ_BITREV_EN
   typedef enum logic [2:0] {IDLE, BITREV, RUN, DRAIN, FINISH} state_t;
`else
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH} state_t;
`endif

   state_t        state_q, state_d;
   logic [3:0]    l_q, l_d, s_q, s_d;
   logic [KW-1:0] k_q, k_d;
   logic [IW-1:0] inflight_q, inflight_d;
   logic          err_q, err_d, armed_q, armed_d;
   logic          valid_q, valid_d, swap_q, swap_d;
   logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [KW-1:0] tw_q, tw_d;
   logic          done_q, busy_q;
   logic          xfer, last_k, load_run;
`ifdef FFT_STAGE_SEQ_BITREV_EN
   logic [AW:0]   idx_q, idx_d;
   logic          swap_phase_q, swap_phase_d;
   logic [AW-1:0] rev;
`endif

   function automatic logic [3:0] clamp_l(input logic [3:0] c);
      if (c == 4'd0) return 4'd1;
      if (32'(c) > LOG2N_MAX) return 4'(LOG2N_MAX);
      return c;
   endfunction

   // Upper-wing address: butterfly group index shifted past the wing bit, offset by position in group.
   function automatic logic [AW-1:0] pair_base(input logic [KW-1:0] k, input logic [3:0] s);
      logic [AW-1:0] kk, pos;
      kk  = AW'(k);
      pos = kk & ((AW'(1) << s) - AW'(1));
      return ((kk >> s) << (s + 4'd1)) | pos;
   endfunction

   function automatic logic [KW-1:0] twiddle(input logic [KW-1:0] k, input logic [3:0] s,
                                             input logic [3:0] l);
      logic [KW-1:0] pos;
      pos = k & ((KW'(1) << s) - KW'(1));
      return pos << (l - 4'd1 - s);
   endfunction

`ifdef FFT_STAGE_SEQ_BITREV_EN
   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] i, input logic [3:0] l);
      logic [AW-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < AW; b++)
         if (b < 32'(l)) r[b] = i[32'(l) - 32'd1 - b];
      return r;
   endfunction
`endif

   assign xfer   = valid_q & bf.bf_ready;
   assign last_k = (k_q == ((KW'(1) << (l_q - 4'd1)) - KW'(1)));

   always_comb begin
      state_d    = state_q;
      l_d        = l_q;
      s_d        = s_q;
      k_d        = k_q;
      inflight_d = inflight_q;
      err_d      = err_q;
      armed_d    = armed_q;
      valid_d    = valid_q;
      swap_d     = swap_q;
      addr_a_d   = addr_a_q;
      addr_b_d   = addr_b_q;
      tw_d       = tw_q;
      load_run   = 1'b0;
`ifdef FFT_STAGE_SEQ_BITREV_EN
      idx_d        = idx_q;
      swap_phase_d = swap_phase_q;
      rev          = '0;
`endif

      // Retires without a matching request only count as errors once a transform has been accepted.
      if (xfer && !bf.bf_done) begin
         if (inflight_q == INFLIGHT_MAX) begin
            if (armed_q) err_d = 1'b1;
         end else begin
            inflight_d = inflight_q + IW'(1);
         end
      end else if (!xfer && bf.bf_done) begin
         if (inflight_q == '0) begin
            if (armed_q) err_d = 1'b1;
         end else begin
            inflight_d = inflight_q - IW'(1);
         end
      end

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               l_d     = clamp_l(cfg_log2n);
               s_d     = '0;
               k_d     = '0;
               err_d   = 1'b0;
               armed_d = 1'b1;
`ifdef FFT_STAGE_SEQ_BITREV_EN
               state_d      = BITREV;
               idx_d        = '0;
               swap_phase_d = 1'b1;
`else
               state_d  = RUN;
               load_run = 1'b1;
`endif
            end
         end
`ifdef FFT_STAGE_SEQ_BITREV_EN
         // Scan one index per cycle; only indices below their reversal produce a swap request.
         BITREV: begin
            if (!valid_q || xfer) begin
               valid_d = 1'b0;
               if (idx_q == ((AW + 1)'(1) << l_q)) begin
                  state_d = DRAIN;
               end else if (inflight_d != INFLIGHT_MAX) begin
                  rev = bitrev(idx_q[AW-1:0], l_q);
                  if (idx_q[AW-1:0] < rev) begin
                     valid_d  = 1'b1;
                     addr_a_d = idx_q[AW-1:0];
                     addr_b_d = rev;
                     tw_d     = '0;
                     swap_d   = 1'b1;
                  end
                  idx_d = idx_q + (AW + 1)'(1);
               end
            end
         end
`endif
         RUN: begin
            if (xfer && last_k) begin
               state_d = DRAIN;
               valid_d = 1'b0;
            end else begin
               if (xfer) k_d = k_q + KW'(1);
               load_run = 1'b1;
            end
         end
         DRAIN: begin
            valid_d = 1'b0;
            if (inflight_d == '0) begin
`ifdef FFT_STAGE_SEQ_BITREV_EN
               if (swap_phase_q) begin
                  swap_phase_d = 1'b0;
                  s_d          = '0;
                  k_d          = '0;
                  state_d      = RUN;
                  load_run     = 1'b1;
               end else
`endif
               if (s_q < l_q - 4'd1) begin
                  s_d      = s_q + 4'd1;
                  k_d      = '0;
                  state_d  = RUN;
                  load_run = 1'b1;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Request fields are recomputed from (s, k), so a stalled request stays stable.
      if (load_run) begin
         valid_d  = (inflight_d != INFLIGHT_MAX);
         addr_a_d = pair_base(k_d, s_d);
         addr_b_d = addr_a_d + (AW'(1) << s_d);
         tw_d     = twiddle(k_d, s_d, l_d);
         swap_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         l_q        <= 4'd1;
         s_q        <= '0;
         k_q        <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
         armed_q    <= 1'b0;
         valid_q    <= 1'b0;
         swap_q     <= 1'b0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         tw_q       <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FFT_STAGE_SEQ_BITREV_EN
         idx_q        <= '0;
         swap_phase_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         l_q        <= l_d;
         s_q        <= s_d;
         k_q        <= k_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         armed_q    <= armed_d;
         valid_q    <= valid_d;
         swap_q     <= swap_d;
         addr_a_q   <= addr_a_d;
         addr_b_q   <= addr_b_d;
         tw_q       <= tw_d;
         done_q     <= (state_d == FINISH);
         busy_q     <= (state_d != IDLE) && (state_d != FINISH);
`ifdef FFT_STAGE_SEQ_BITREV_EN
         idx_q        <= idx_d;
         swap_phase_q <= swap_phase_d;
`endif
      end
   end

   assign bf.bf_valid   = valid_q;
   assign bf.bf_addr_a  = addr_a_q;
   assign bf.bf_addr_b  = addr_b_q;
   assign bf.bf_tw_addr = tw_q;
   assign bf.bf_swap    = swap_q;
   assign stage         = s_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
endmodule
